gate_bist: RTL and testbench

GATE_BIST -- requirements
Module: gate_bist

---
 rtl/gate_bist.sv | 137 +++++++++++++
 tb/tb_gate_bist.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gate_bist.sv
// ============================================================================
//  Module      : gate_bist
//  Description : Exhaustive 2-input logic cell self-test. Applies the four
//                {A,B} vectors and compares Y against a latched truth table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_bist #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] truth,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_map
);

  localparam logic [7:0] c_last_hold = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_idx;
  logic [7:0] r_hold;
  logic [3:0] r_truth;
  logic [3:0] r_map;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail_map;

  logic       w_mismatch;
  logic [3:0] w_map_next;
  logic [1:0] w_idx_next;

  // Working map including the sample taken on this edge, so the final
  // vector's result is visible when DONE is entered.
  always_comb begin
    w_mismatch         = (y_in != r_truth[r_idx]);
    w_map_next         = r_map;
    w_map_next[r_idx]  = w_mismatch;
    w_idx_next         = r_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_hold     <= 8'd0;
      r_truth    <= 4'd0;
      r_map      <= 4'd0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_map <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_truth <= truth;
            r_idx   <= 2'd0;
            r_hold  <= 8'd0;
            r_map   <= 4'd0;
            r_busy  <= 1'b1;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
          end else if (r_hold == c_last_hold) begin
            r_hold <= 8'd0;
            r_map  <= w_map_next;
            if (r_idx == 2'd3) begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_a        <= 1'b0;
              r_b        <= 1'b0;
              r_fail_map <= w_map_next;
              r_pass     <= (w_map_next == 4'd0);
            end else begin
              r_idx <= w_idx_next;
              r_a   <= w_idx_next[1];
              r_b   <= w_idx_next[0];
            end
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
        end
      endcase
    end
  end

  assign a_out    = r_a;
  assign b_out    = r_b;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign fail_map = r_fail_map;

endmodule

`default_nettype wire

// File: tb/tb_gate_bist.sv
// ============================================================================
//  Module      : tb_gate_bist
//  Description : Self-checking bench for gate_bist at SETTLE_CYCLES 1, 2, 3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_bist;

  localparam int c_s [3] = '{1, 2, 3};

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [3:0] truth;
  logic       a_o [3];
  logic       b_o [3];
  logic       y_i [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic       pass_o [3];
  logic [3:0] fm_o [3];
  logic [3:0] yt [3];

  always #5 clk = ~clk;

  // Each cell under test is a plain truth table indexed by {A,B}.
  assign y_i[0] = yt[0][{a_o[0], b_o[0]}];
  assign y_i[1] = yt[1][{a_o[1], b_o[1]}];
  assign y_i[2] = yt[2][{a_o[2], b_o[2]}];

  gate_bist #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .truth(truth),
    .a_out(a_o[0]), .b_out(b_o[0]), .y_in(y_i[0]), .busy(busy_o[0]),
    .done(done_o[0]), .pass(pass_o[0]), .fail_map(fm_o[0]));
  gate_bist #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .truth(truth),
    .a_out(a_o[1]), .b_out(b_o[1]), .y_in(y_i[1]), .busy(busy_o[1]),
    .done(done_o[1]), .pass(pass_o[1]), .fail_map(fm_o[1]));
  gate_bist #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .truth(truth),
    .a_out(a_o[2]), .b_out(b_o[2]), .y_in(y_i[2]), .busy(busy_o[2]),
    .done(done_o[2]), .pass(pass_o[2]), .fail_map(fm_o[2]));

  // Reference model: time since the start edge decides everything.
  bit         m_run [3];
  bit         m_done [3];
  int         m_t [3];
  logic [3:0] m_truth [3];
  logic [3:0] m_yt [3];
  logic [3:0] m_fail [3];
  bit         m_pass [3];

  int total = 0;
  int bad   = 0;
  int cyc;
  int ndone [3];
  int dcyc [3];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst_v, input bit st_v, input bit ab_v, input logic [3:0] tr_v);
    int vec;
    reset = rst_v;
    start = st_v;
    abort = ab_v;
    truth = tr_v;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst_v) begin
        m_run[k] = 0; m_done[k] = 0; m_fail[k] = 4'd0; m_pass[k] = 0;
      end else if (m_done[k]) begin
        m_done[k] = 0;
      end else if (m_run[k]) begin
        if (ab_v) m_run[k] = 0;
        else begin
          m_t[k]++;
          if (m_t[k] == 4 * c_s[k] + 1) begin
            m_run[k]  = 0;
            m_done[k] = 1;
            m_fail[k] = m_yt[k] ^ m_truth[k];
            m_pass[k] = (m_fail[k] == 4'd0);
          end
        end
      end else if (st_v) begin
        m_run[k] = 1; m_t[k] = 1; m_truth[k] = tr_v; m_yt[k] = yt[k];
      end
    end
    cyc++;
    #1;
    for (int k = 0; k < 3; k++) begin
      vec = m_run[k] ? (m_t[k] - 1) / c_s[k] : 0;
      chk($sformatf("busy%0d", k), 8'(busy_o[k]), 8'(m_run[k]));
      chk($sformatf("done%0d", k), 8'(done_o[k]), 8'(m_done[k]));
      chk($sformatf("a%0d", k), 8'(a_o[k]), 8'((vec >> 1) & 1));
      chk($sformatf("b%0d", k), 8'(b_o[k]), 8'(vec & 1));
      chk($sformatf("fmap%0d", k), 8'(fm_o[k]), 8'(m_fail[k]));
      chk($sformatf("pass%0d", k), 8'(pass_o[k]), 8'(m_pass[k]));
      if (done_o[k] === 1'b1) begin
        ndone[k]++;
        if (dcyc[k] < 0) dcyc[k] = cyc;
      end
    end
  endtask

  task automatic clear_counts();
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      ndone[k] = 0;
      dcyc[k]  = -1;
    end
  endtask

  // Start at cycle 0; redundant starts in cycles 2 and 4, optional start at s2.
  task automatic run_one(input logic [3:0] tr, input logic [3:0] yv, input int s2);
    for (int k = 0; k < 3; k++) yt[k] = yv;
    clear_counts();
    step(0, 1, 0, tr);
    for (int c = 1; c <= 14; c++)
      step(0, (c == 2 || c == 4 || c == s2), 0, (c == s2) ? tr : 4'($urandom));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("done_cycle%0d", k), 8'(dcyc[k]), 8'(4 * c_s[k] + 1));
      chk($sformatf("done_count%0d", k), 8'(ndone[k]), (s2 > 0 && k == 0) ? 8'd2 : 8'd1);
    end
  endtask

  // Interrupt a run in cycle 4 with either reset or abort.
  task automatic cut_run(input bit use_reset);
    for (int k = 0; k < 3; k++) yt[k] = 4'b1001;
    clear_counts();
    step(0, 1, 0, 4'b0110);
    for (int c = 1; c <= 16; c++)
      step(use_reset && c == 4, 0, !use_reset && c == 4, 4'($urandom));
    for (int k = 0; k < 3; k++)
      chk($sformatf("cut_done_count%0d", k), 8'(ndone[k]), 8'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      yt[k] = 4'd0; m_run[k] = 0; m_done[k] = 0; m_t[k] = 0;
      m_fail[k] = 4'd0; m_pass[k] = 0; m_truth[k] = 4'd0; m_yt[k] = 4'd0;
    end
    clear_counts();
    reset = 1'b1; start = 1'b0; abort = 1'b0; truth = 4'd0;
    step(1, 1, 1, 4'hf);
    step(1, 0, 0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_fmap%0d", k), 8'(fm_o[k]), 8'h0);
      chk($sformatf("rst_pass%0d", k), 8'(pass_o[k]), 8'h0);
    end

    run_one(4'b1000, 4'b1000, -1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("and_fmap%0d", k), 8'(fm_o[k]), 8'h0);
      chk($sformatf("and_pass%0d", k), 8'(pass_o[k]), 8'h1);
    end
    run_one(4'b1000, 4'b0000, -1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("y0_fmap%0d", k), 8'(fm_o[k]), 8'b1000);
      chk($sformatf("y0_pass%0d", k), 8'(pass_o[k]), 8'h0);
    end
    run_one(4'b1000, 4'b1111, -1);
    for (int k = 0; k < 3; k++) chk($sformatf("y1_fmap%0d", k), 8'(fm_o[k]), 8'b0111);
    run_one(4'b1000, 4'b1110, -1);
    for (int k = 0; k < 3; k++) chk($sformatf("or_fmap%0d", k), 8'(fm_o[k]), 8'b0110);

    cut_run(1'b0);
    for (int k = 0; k < 3; k++) chk($sformatf("abort_keep%0d", k), 8'(fm_o[k]), 8'b0110);

    run_one(4'b1110, 4'b1110, 6);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("or_ok_fmap%0d", k), 8'(fm_o[k]), 8'h0);
      chk($sformatf("or_ok_pass%0d", k), 8'(pass_o[k]), 8'h1);
    end

    cut_run(1'b1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_fmap%0d", k), 8'(fm_o[k]), 8'h0);
      chk($sformatf("reset_pass%0d", k), 8'(pass_o[k]), 8'h0);
    end

    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++)
        if (!m_run[k]) yt[k] = 4'($urandom);
      step(($urandom % 100) == 0, ($urandom % 4) == 0, ($urandom % 40) == 0, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
